// File: rtl/dma_timing_ctrl.sv
// Timing/control stage of an 8237A-style DMA controller: fixed-priority arbitration
// and single-transfer bus sequencing (SI..S4) with register-file update strobes.
module dma_timing_ctrl #(
   parameter int NCH = 4,
   parameter int AW  = 16,
   parameter int WW  = 16,
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [NCH-1:0]      DREQ,
   input  logic                HLDA,
   input  logic                READY,
   input  logic                EOP_n_in,
   input  logic                cmdDisable,
   input  logic [NCH-1:0]      maskBits,
   input  logic [NCH-1:0]      reqBits,
   input  logic [2*NCH-1:0]    modeXfer,
   input  logic [NCH-1:0]      modeDec,
   input  logic [AW*NCH-1:0]   currAddr,
   input  logic [WW*NCH-1:0]   currWord,
   output logic                HRQ,
   output logic [NCH-1:0]      DACK,
   output logic                AEN,
   output logic                ADSTB,
   output logic [AW-1:0]       ADDR,
   output logic                MEMR_n,
   output logic                MEMW_n,
   output logic                IOR_n,
   output logic                IOW_n,
   output logic                EOP_n_out,
   output logic                updEn,
   output logic [CW-1:0]       updCh,
   output logic [AW-1:0]       updAddr,
   output logic [WW-1:0]       updWord,
   output logic [NCH-1:0]      tcSet,
   output logic [NCH-1:0]      reqClr
);

   typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

   state_t          r_state, w_next;
   logic [CW-1:0]   r_ch;
   logic            r_eop;
   logic [NCH-1:0]  w_eff;
   logic [CW-1:0]   w_pri;
   logic [NCH-1:0]  w_pri_oh, w_ch_oh;
   logic [AW-1:0]   w_pri_addr, w_cur_addr;
   logic [WW-1:0]   w_cur_word;
   logic [1:0]      w_cur_mode;
   logic            w_tc;

   assign w_eff    = (DREQ | reqBits) & ~maskBits;
   assign w_pri_oh = NCH'(1) << w_pri;
   assign w_ch_oh  = NCH'(1) << r_ch;
   // An external EOP on the S3->S4 edge counts as well as one latched earlier.
   assign w_tc     = (w_cur_word == '0) || r_eop || !EOP_n_in;

   always_comb begin
      w_pri      = '0;
      w_pri_addr = '0;
      w_cur_addr = '0;
      w_cur_word = '0;
      w_cur_mode = '0;
      for (int i = NCH-1; i >= 0; i--)
         if (w_eff[i]) w_pri = CW'(i);
      for (int i = 0; i < NCH; i++) begin
         if (w_pri == CW'(i)) w_pri_addr = currAddr[i*AW +: AW];
         if (r_ch == CW'(i)) begin
            w_cur_addr = currAddr[i*AW +: AW];
            w_cur_word = currWord[i*WW +: WW];
            w_cur_mode = modeXfer[i*2 +: 2];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= SI;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         SI:      if (!cmdDisable && (w_eff != '0)) w_next = S0;
         S0:      if (w_eff == '0) w_next = SI;
                  else if (HLDA)   w_next = S1;
         S1:      w_next = S2;
         S2:      w_next = S3;
         S3:      if (READY) w_next = S4;
         S4:      w_next = SI;
         default: w_next = SI;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         HRQ       <= 1'b0;
         DACK      <= '0;
         AEN       <= 1'b0;
         ADSTB     <= 1'b0;
         ADDR      <= '0;
         MEMR_n    <= 1'b1;
         MEMW_n    <= 1'b1;
         IOR_n     <= 1'b1;
         IOW_n     <= 1'b1;
         EOP_n_out <= 1'b1;
         updEn     <= 1'b0;
         updCh     <= '0;
         updAddr   <= '0;
         updWord   <= '0;
         tcSet     <= '0;
         reqClr    <= '0;
         r_ch      <= '0;
         r_eop     <= 1'b0;
      end else begin
         updEn     <= 1'b0;
         tcSet     <= '0;
         reqClr    <= '0;
         EOP_n_out <= 1'b1;
         case (r_state)
            SI: if (w_next == S0) HRQ <= 1'b1;
            S0: begin
               if (w_next == SI) HRQ <= 1'b0;
               else if (w_next == S1) begin
                  r_ch  <= w_pri;
                  AEN   <= 1'b1;
                  ADSTB <= 1'b1;
                  ADDR  <= w_pri_addr;
                  DACK  <= w_pri_oh;
               end
            end
            S1: begin
               ADSTB <= 1'b0;
               // Read = memory to I/O, write = I/O to memory; verify drives nothing.
               if (w_cur_mode == 2'b10) begin
                  MEMR_n <= 1'b0;
                  IOW_n  <= 1'b0;
               end else if (w_cur_mode == 2'b01) begin
                  IOR_n  <= 1'b0;
                  MEMW_n <= 1'b0;
               end
            end
            S2: if (!EOP_n_in) r_eop <= 1'b1;
            S3: begin
               if (!EOP_n_in) r_eop <= 1'b1;
               if (READY) begin
                  MEMR_n  <= 1'b1;
                  MEMW_n  <= 1'b1;
                  IOR_n   <= 1'b1;
                  IOW_n   <= 1'b1;
                  DACK    <= '0;
                  AEN     <= 1'b0;
                  updEn   <= 1'b1;
                  updCh   <= r_ch;
                  updAddr <= modeDec[r_ch] ? w_cur_addr - AW'(1) : w_cur_addr + AW'(1);
                  updWord <= w_cur_word - WW'(1);
                  reqClr  <= reqBits & w_ch_oh;
                  if (w_tc) begin
                     EOP_n_out <= 1'b0;
                     tcSet     <= w_ch_oh;
                  end
               end
            end
            S4: begin
               HRQ   <= 1'b0;
               r_eop <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Self-checking bench for dma_timing_ctrl: directed scenarios plus randomized
// single transfers checked against a transfer-level reference model.
module tb_dma_timing_ctrl;
   localparam int NCH = 4;
   localparam int AW  = 16;
   localparam int WW  = 16;

   logic              CLK = 1'b0;
   logic              RESET, HLDA, READY, EOP_n_in, cmdDisable;
   logic [NCH-1:0]    DREQ, maskBits, reqBits, modeDec;
   logic [2*NCH-1:0]  modeXfer;
   logic [AW*NCH-1:0] currAddr;
   logic [WW*NCH-1:0] currWord;
   logic              HRQ, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n, EOP_n_out, updEn;
   logic [NCH-1:0]    DACK, tcSet, reqClr;
   logic [AW-1:0]     ADDR, updAddr;
   logic [WW-1:0]     updWord;
   logic [1:0]        updCh;
   logic [3:0]        strobes;

   int checks   = 0;
   int failures = 0;

   assign strobes = {MEMR_n, MEMW_n, IOR_n, IOW_n};

   always #5 CLK = ~CLK;

   dma_timing_ctrl #(.NCH(NCH), .AW(AW), .WW(WW)) dut (
      .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .READY(READY),
      .EOP_n_in(EOP_n_in), .cmdDisable(cmdDisable), .maskBits(maskBits),
      .reqBits(reqBits), .modeXfer(modeXfer), .modeDec(modeDec),
      .currAddr(currAddr), .currWord(currWord), .HRQ(HRQ), .DACK(DACK),
      .AEN(AEN), .ADSTB(ADSTB), .ADDR(ADDR), .MEMR_n(MEMR_n), .MEMW_n(MEMW_n),
      .IOR_n(IOR_n), .IOW_n(IOW_n), .EOP_n_out(EOP_n_out), .updEn(updEn),
      .updCh(updCh), .updAddr(updAddr), .updWord(updWord), .tcSet(tcSet),
      .reqClr(reqClr)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete transfer from idle. eopm: 0 none, 1 EOP in S2, 2 EOP in last S3
   // cycle, 3 EOP during S0/S1 (must be ignored). drop: HLDA and DREQ fall after S1.
   task automatic xfer(input string nm, input int waits, input int eopm,
                       input int hdly, input bit drop);
      logic [NCH-1:0] eff;
      int             ch;
      logic [AW-1:0]  a, exp_a;
      logic [WW-1:0]  w, exp_w;
      logic [1:0]     m;
      logic [3:0]     exp_str;
      bit             tc;
      eff = (DREQ | reqBits) & ~maskBits;
      ch  = 0;
      for (int i = NCH-1; i >= 0; i--) if (eff[i]) ch = i;
      a       = currAddr[ch*AW +: AW];
      w       = currWord[ch*WW +: WW];
      m       = modeXfer[ch*2 +: 2];
      exp_a   = modeDec[ch] ? a - 16'd1 : a + 16'd1;
      exp_w   = w - 16'd1;
      exp_str = (m == 2'b10) ? 4'b0110 : (m == 2'b01) ? 4'b1001 : 4'b1111;
      tc      = (w == 16'd0) || (eopm == 1) || (eopm == 2);

      if (eopm == 3) EOP_n_in = 1'b0;
      tick();
      chk({nm, ".hrq"}, HRQ, 1);
      for (int k = 0; k < hdly; k++) begin
         tick();
         chk({nm, ".hrq_wait"}, HRQ, 1);
         chk({nm, ".dack_wait"}, DACK, 0);
      end
      HLDA = 1'b1;
      tick();
      chk({nm, ".s1_aen"}, AEN, 1);
      chk({nm, ".s1_adstb"}, ADSTB, 1);
      chk({nm, ".s1_addr"}, ADDR, a);
      chk({nm, ".s1_dack"}, DACK, 1 << ch);
      chk({nm, ".s1_str"}, strobes, 4'hF);
      if (drop) begin
         HLDA = 1'b0;
         DREQ = '0;
      end
      tick();
      if (eopm == 3) EOP_n_in = 1'b1;
      chk({nm, ".s2_adstb"}, ADSTB, 0);
      chk({nm, ".s2_str"}, strobes, exp_str);
      chk({nm, ".s2_dack"}, DACK, 1 << ch);
      if (eopm == 1) EOP_n_in = 1'b0;
      tick();
      if (eopm == 1) EOP_n_in = 1'b1;
      chk({nm, ".s3_str"}, strobes, exp_str);
      for (int k = 0; k < waits; k++) begin
         READY = 1'b0;
         tick();
         chk({nm, ".wait_str"}, strobes, exp_str);
         chk({nm, ".wait_upd"}, updEn, 0);
      end
      READY = 1'b1;
      if (eopm == 2) EOP_n_in = 1'b0;
      tick();
      EOP_n_in = 1'b1;
      chk({nm, ".s4_upden"}, updEn, 1);
      chk({nm, ".s4_updch"}, updCh, ch);
      chk({nm, ".s4_updaddr"}, updAddr, exp_a);
      chk({nm, ".s4_updword"}, updWord, exp_w);
      chk({nm, ".s4_tcset"}, tcSet, tc ? (1 << ch) : 0);
      chk({nm, ".s4_eop"}, EOP_n_out, tc ? 0 : 1);
      chk({nm, ".s4_reqclr"}, reqClr, reqBits[ch] ? (1 << ch) : 0);
      chk({nm, ".s4_str"}, strobes, 4'hF);
      chk({nm, ".s4_dack"}, DACK, 0);
      chk({nm, ".s4_aen"}, AEN, 0);
      HLDA    = 1'b0;
      DREQ    = '0;
      reqBits = '0;
      tick();
      chk({nm, ".si_hrq"}, HRQ, 0);
      chk({nm, ".si_upden"}, updEn, 0);
      chk({nm, ".si_tcset"}, tcSet, 0);
      chk({nm, ".si_eop"}, EOP_n_out, 1);
      chk({nm, ".si_addr"}, ADDR, a);
   endtask

   initial begin
      RESET = 1'b1; HLDA = 1'b0; READY = 1'b1; EOP_n_in = 1'b1; cmdDisable = 1'b0;
      DREQ = '0; maskBits = '0; reqBits = '0; modeDec = '0; modeXfer = '0;
      currAddr = '0; currWord = '0;
      tick();
      tick();
      chk("rst.hrq", HRQ, 0);
      chk("rst.dack", DACK, 0);
      chk("rst.aen", AEN, 0);
      chk("rst.addr", ADDR, 0);
      chk("rst.str", strobes, 4'hF);
      chk("rst.eop", EOP_n_out, 1);
      chk("rst.upd", {updEn, updCh, updAddr, updWord, tcSet, reqClr}, 0);
      RESET = 1'b0;
      tick();

      // Controller disabled: no hold request.
      cmdDisable = 1'b1; DREQ = 4'b0001;
      tick(); tick();
      chk("dis.hrq", HRQ, 0);
      cmdDisable = 1'b0;
      tick();
      chk("abort.hrq_up", HRQ, 1);
      DREQ = '0;
      tick();
      chk("abort.hrq_down", HRQ, 0);
      tick();

      // Ch1 read, increment, no TC, HLDA one cycle after HRQ.
      DREQ = 4'b0010; modeXfer[3:2] = 2'b10; modeDec[1] = 1'b0;
      currAddr[31:16] = 16'h1000; currWord[31:16] = 16'd3;
      xfer("ch1_read", 0, 0, 1, 0);

      // Ch2 write, decrement from 0, count 0 -> wrap and TC.
      DREQ = 4'b0100; modeXfer[5:4] = 2'b01; modeDec[2] = 1'b1;
      currAddr[47:32] = 16'h0000; currWord[47:32] = 16'd0;
      xfer("ch2_wrap", 0, 0, 0, 0);

      // Masking and priority.
      DREQ = 4'b1010; maskBits = 4'b0010; currWord[63:48] = 16'd9;
      xfer("mask_ch3", 0, 0, 0, 0);
      DREQ = 4'b1010; maskBits = 4'b0000;
      xfer("prio_ch1", 0, 0, 0, 0);

      // Three wait states.
      DREQ = 4'b0010;
      xfer("ready3", 3, 0, 0, 0);

      // External EOP in S2 on a software request for ch0.
      DREQ = '0; reqBits = 4'b0001; modeXfer[1:0] = 2'b00;
      currAddr[15:0] = 16'h2222; currWord[15:0] = 16'd5;
      xfer("eop_sw", 0, 1, 0, 0);

      // Reset asserted mid-transfer in S3.
      DREQ = 4'b0001; modeXfer[1:0] = 2'b10;
      tick();
      HLDA = 1'b1;
      tick(); tick();
      READY = 1'b0;
      tick();
      chk("midrst.s3_str", strobes, 4'b0110);
      RESET = 1'b1;
      tick();
      RESET = 1'b0; READY = 1'b1; HLDA = 1'b0; DREQ = '0;
      chk("midrst.hrq", HRQ, 0);
      chk("midrst.str", strobes, 4'hF);
      chk("midrst.dack", DACK, 0);
      chk("midrst.addr", ADDR, 0);
      chk("midrst.eop", EOP_n_out, 1);
      for (int k = 0; k < 4; k++) begin
         chk("midrst.no_upd", updEn, 0);
         tick();
      end

      // Randomized transfers.
      for (int n = 0; n < 40; n++) begin
         modeXfer = 8'($urandom);
         modeDec  = 4'($urandom);
         currAddr = {$urandom, $urandom};
         for (int c = 0; c < NCH; c++)
            currWord[c*WW +: WW] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         DREQ     = 4'($urandom);
         reqBits  = 4'($urandom);
         maskBits = 4'($urandom);
         if (((DREQ | reqBits) & ~maskBits) == '0) begin
            maskBits = '0;
            DREQ[$urandom_range(0, NCH-1)] = 1'b1;
         end
         xfer("rnd", $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dma_timing_ctrl.md
Name: dma_timing_ctrl

Overview:
- Timing-and-control stage of the 8237A-style DMA controller; sits directly downstream of the DMA register file.
- Consumes current address/word counts, mode, command and mask contents; arbitrates channel requests and sequences single-transfer bus cycles (SI, S0, S1, S2, S3, S4).
- Returns per-transfer update strobes to the register file: new address, new count, TC status bits, request clear.

Parameters:
NCH, 4, number of DMA channels
AW, 16, address / current-address register width
WW, 16, word-count register width

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
DREQ  in  NCH  channel DMA requests, active high, level
HLDA  in  1  hold acknowledge from CPU
READY  in  1  memory/IO ready; low inserts wait states
EOP_n_in  in  1  external end-of-process, active low
cmdDisable  in  1  commandReg bit 2 (controller disable)
maskBits  in  NCH  maskReg contents (1 = masked)
reqBits  in  NCH  requestReg software requests
modeXfer  in  2*NCH  per-channel modeReg[3:2]: 00 verify, 01 write, 10 read, 11 illegal
modeDec  in  NCH  per-channel modeReg[5]: 1 = address decrement
currAddr  in  AW*NCH  packed current address registers
currWord  in  WW*NCH  packed current word count registers
HRQ  out  1  hold request to CPU
DACK  out  NCH  channel acknowledge, active high
AEN  out  1  address enable
ADSTB  out  1  upper-address strobe
ADDR  out  AW  transfer address
MEMR_n, MEMW_n, IOR_n, IOW_n  out  1 each  bus strobes, active low
EOP_n_out  out  1  terminal-count pulse, active low
updEn  out  1  one-cycle register-update strobe
updCh  out  2  channel being updated
updAddr  out  AW  next current address
updWord  out  WW  next current word count
tcSet  out  NCH  one-cycle pulse: set status TC bit
reqClr  out  NCH  one-cycle pulse: clear software request bit

Behaviour:
- Reset (sync, CLK edge with RESET=1): state=SI; HRQ, DACK, AEN, ADSTB, updEn, tcSet, reqClr = 0; ADDR=0; updAddr=0; updWord=0; updCh=0; all *_n outputs = 1. RESET in any state overrides everything, including mid-transfer.
- Effective request: eff = (DREQ | reqBits) & ~maskBits. Fixed priority, channel 0 highest. Channel is latched in S0 when HLDA is first seen and held until SI.
- SI: if !cmdDisable and eff!=0 -> S0, HRQ=1 registered.
- S0: HRQ held; stay until HLDA=1 -> S1. If eff drops to 0 before HLDA -> SI, HRQ=0.
- S1: AEN=1, ADSTB=1, ADDR=currAddr[ch], DACK[ch]=1 -> S2.
- S2: ADSTB=0. Read (10): MEMR_n=0, IOW_n=0. Write (01): IOR_n=0, MEMW_n=0. Verify/illegal: no strobes. -> S3.
- S3: strobes held; READY=0 keeps state (wait states, unbounded); READY=1 -> S4.
- S4: strobes, DACK, AEN released.
  - updEn=1, updCh=ch, updAddr=currAddr[ch]±1 (mod 2^AW), updWord=currWord[ch]-1 (mod 2^WW).
  - reqClr[ch]=1 if reqBits[ch].
  - Terminal count when currWord[ch]==0 (count wraps to all-ones): EOP_n_out=0 and tcSet[ch]=1 for this cycle only.
  - -> SI, HRQ=0 (single mode: bus is released after every transfer).
- EOP_n_in=0 sampled in S2 or S3: latched; S4 then treats the transfer as TC (EOP_n_out pulse, tcSet) regardless of count. EOP_n_in in SI/S0/S1 is ignored.
- HLDA dropping mid-transfer is ignored; the cycle completes.
- DREQ deasserting after S1 does not abort the transfer.
- ADDR holds its last value outside S1–S4.
- Fixed latency HLDA -> S4 is 4 cycles plus wait states.

Test Plan:
- Reset: assert RESET in S3 mid-transfer -> next edge state SI, all strobes high, HRQ=0, updEn never pulsed.
- Ch1 read, currAddr=0x1000, currWord=3, modeDec=0, HLDA one cycle after HRQ -> ADDR=0x1000 in S1, MEMR_n/IOW_n low for S2–S3, updAddr=0x1001, updWord=2, no EOP.
- Ch2 write, decrement, currAddr=0x0000, currWord=0 -> updAddr=0xFFFF, updWord=0xFFFF, EOP_n_out low 1 cycle, tcSet=4'b0100.
- DREQ=4'b1010, maskBits=4'b0010 -> ch3 serviced, DACK=4'b1000; with maskBits=0 -> ch1 serviced.
- READY low 3 cycles in S3 -> strobes held exactly 3 extra cycles, then S4.
- EOP_n_in low in S2, currWord=5 -> tcSet pulse, EOP_n_out pulse, updWord=4; reqBits[0]=1 with DREQ=0 -> ch0 serviced, reqClr[0] pulsed in S4.
